// File: rtl/price_sample_writer.sv
// Write-side controller for the per-stock mid-price history memory: filters
// crossed/invalid/unchanged quotes and issues circular-buffer write strobes.
module price_sample_writer #(
  parameter int DATA_WIDTH  = 32,
  parameter int BUFFER_SIZE = 20,
  parameter int NUM_STOCKS  = 4
) (
  input  logic                                    i_clk,
  input  logic                                    i_reset_n,
  input  logic                                    i_valid,
  output logic                                    o_ready,
  input  logic [DATA_WIDTH-1:0]                   i_best_ask,
  input  logic [DATA_WIDTH-1:0]                   i_best_bid,
  input  logic [$clog2(NUM_STOCKS)-1:0]           i_stock_id,
  input  logic                                    i_flush,
  input  logic [$clog2(NUM_STOCKS)-1:0]           i_flush_stock_id,
  output logic                                    o_valid,
  output logic [$clog2(NUM_STOCKS*BUFFER_SIZE)-1:0] o_write_address,
  output logic [$clog2(NUM_STOCKS)-1:0]           o_stock_id,
  output logic [DATA_WIDTH-1:0]                   o_best_ask,
  output logic [DATA_WIDTH-1:0]                   o_best_bid,
  output logic [NUM_STOCKS-1:0]                   o_window_full,
  output logic                                    o_crossed
);
  localparam int SID_W  = $clog2(NUM_STOCKS);
  localparam int ADDR_W = $clog2(NUM_STOCKS*BUFFER_SIZE);
  localparam int PTR_W  = (BUFFER_SIZE > 1) ? $clog2(BUFFER_SIZE) : 1;
  localparam int FILL_W = $clog2(BUFFER_SIZE+1);

  typedef enum logic [1:0] {EMPTY, FILLING, FULL} state_e;

  state_e                state_q    [NUM_STOCKS];
  state_e                state_d    [NUM_STOCKS];
  logic [PTR_W-1:0]      ptr_q      [NUM_STOCKS];
  logic [PTR_W-1:0]      ptr_d      [NUM_STOCKS];
  logic [FILL_W-1:0]     fill_q     [NUM_STOCKS];
  logic [FILL_W-1:0]     fill_d     [NUM_STOCKS];
  logic [DATA_WIDTH-1:0] last_ask_q [NUM_STOCKS];
  logic [DATA_WIDTH-1:0] last_ask_d [NUM_STOCKS];
  logic [DATA_WIDTH-1:0] last_bid_q [NUM_STOCKS];
  logic [DATA_WIDTH-1:0] last_bid_d [NUM_STOCKS];

  logic                  valid_q, valid_d;
  logic                  crossed_q, crossed_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [SID_W-1:0]      sid_q, sid_d;
  logic [DATA_WIDTH-1:0] ask_q, ask_d;
  logic [DATA_WIDTH-1:0] bid_q, bid_d;

  logic accept, id_ok, is_crossed;

  assign o_ready    = !i_flush;
  assign accept     = i_valid && o_ready;
  assign id_ok      = int'(i_stock_id) < NUM_STOCKS;
  assign is_crossed = i_best_ask < i_best_bid;

  // Flush and accept are mutually exclusive because o_ready drops during flush.
  always_comb begin
    valid_d   = 1'b0;
    crossed_d = accept && id_ok && is_crossed;
    addr_d    = addr_q;
    sid_d     = sid_q;
    ask_d     = ask_q;
    bid_d     = bid_q;
    for (int s = 0; s < NUM_STOCKS; s++) begin
      state_d[s]    = state_q[s];
      ptr_d[s]      = ptr_q[s];
      fill_d[s]     = fill_q[s];
      last_ask_d[s] = last_ask_q[s];
      last_bid_d[s] = last_bid_q[s];
      if (i_flush && int'(i_flush_stock_id) == s) begin
        state_d[s] = EMPTY;
        ptr_d[s]   = '0;
        fill_d[s]  = '0;
      end else if (accept && int'(i_stock_id) == s && !is_crossed &&
                   !(state_q[s] != EMPTY && i_best_ask == last_ask_q[s] &&
                     i_best_bid == last_bid_q[s])) begin
        valid_d       = 1'b1;
        addr_d        = ADDR_W'(s*BUFFER_SIZE + int'(ptr_q[s]));
        sid_d         = SID_W'(s);
        ask_d         = i_best_ask;
        bid_d         = i_best_bid;
        ptr_d[s]      = (int'(ptr_q[s]) == BUFFER_SIZE-1) ? '0 : ptr_q[s] + PTR_W'(1);
        fill_d[s]     = (int'(fill_q[s]) == BUFFER_SIZE) ? fill_q[s] : fill_q[s] + FILL_W'(1);
        last_ask_d[s] = i_best_ask;
        last_bid_d[s] = i_best_bid;
        state_d[s]    = (int'(fill_q[s]) >= BUFFER_SIZE-1) ? FULL : FILLING;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      valid_q   <= 1'b0;
      crossed_q <= 1'b0;
      addr_q    <= '0;
      sid_q     <= '0;
      ask_q     <= '0;
      bid_q     <= '0;
      for (int s = 0; s < NUM_STOCKS; s++) begin
        state_q[s]    <= EMPTY;
        ptr_q[s]      <= '0;
        fill_q[s]     <= '0;
        last_ask_q[s] <= '0;
        last_bid_q[s] <= '0;
      end
    end else begin
      valid_q    <= valid_d;
      crossed_q  <= crossed_d;
      addr_q     <= addr_d;
      sid_q      <= sid_d;
      ask_q      <= ask_d;
      bid_q      <= bid_d;
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      fill_q     <= fill_d;
      last_ask_q <= last_ask_d;
      last_bid_q <= last_bid_d;
    end
  end

  always_comb begin
    for (int s = 0; s < NUM_STOCKS; s++) o_window_full[s] = (state_q[s] == FULL);
  end

  assign o_valid         = valid_q;
  assign o_crossed       = crossed_q;
  assign o_write_address = addr_q;
  assign o_stock_id      = sid_q;
  assign o_best_ask      = ask_q;
  assign o_best_bid      = bid_q;
endmodule

// File: tb/tb_price_sample_writer.sv
// Bench for price_sample_writer: directed scenarios plus randomized traffic
// scored against a per-stock write-count model.
module tb_price_sample_writer;
  localparam int DW = 32, BS = 20, NS = 4;

  logic          clk = 1'b0, rst_n = 1'b0, valid = 1'b0, flush = 1'b0;
  logic [DW-1:0] ask = '0, bid = '0;
  logic [1:0]    sid = '0, fsid = '0;
  logic          ready, o_valid, o_crossed;
  logic [6:0]    o_addr;
  logic [1:0]    o_sid;
  logic [DW-1:0] o_ask, o_bid;
  logic [NS-1:0] o_full;

  int passed = 0, total = 0;

  // Model: writes since last flush/reset per stock, plus last written quote.
  int            m_cnt [NS];
  logic [DW-1:0] m_ask [NS], m_bid [NS];
  logic          e_valid, e_crossed, s_ready;
  logic [6:0]    e_addr;
  logic [1:0]    e_sid;
  logic [DW-1:0] e_ask, e_bid;
  logic [NS-1:0] e_full;
  logic [78:0]   obs, exp_v;

  assign obs   = {o_valid, o_crossed, o_addr, o_sid, o_ask, o_bid, o_full};
  assign exp_v = {e_valid, e_crossed, e_addr, e_sid, e_ask, e_bid, e_full};

  price_sample_writer #(.DATA_WIDTH(DW), .BUFFER_SIZE(BS), .NUM_STOCKS(NS)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_valid(valid), .o_ready(ready),
    .i_best_ask(ask), .i_best_bid(bid), .i_stock_id(sid),
    .i_flush(flush), .i_flush_stock_id(fsid),
    .o_valid(o_valid), .o_write_address(o_addr), .o_stock_id(o_sid),
    .o_best_ask(o_ask), .o_best_bid(o_bid), .o_window_full(o_full),
    .o_crossed(o_crossed)
  );

  always #5 clk = ~clk;

  task automatic model_edge(input bit do_rst);
    e_valid   = 1'b0;
    e_crossed = 1'b0;
    if (do_rst) begin
      for (int s = 0; s < NS; s++) begin m_cnt[s] = 0; m_ask[s] = '0; m_bid[s] = '0; end
      e_addr = '0; e_sid = '0; e_ask = '0; e_bid = '0;
    end else if (flush) begin
      m_cnt[fsid] = 0;
    end else if (valid) begin
      if (ask < bid) e_crossed = 1'b1;
      else if (!(m_cnt[sid] > 0 && ask == m_ask[sid] && bid == m_bid[sid])) begin
        e_valid = 1'b1;
        e_addr  = 7'(int'(sid)*BS + m_cnt[sid] % BS);
        e_sid   = sid;
        e_ask   = ask;
        e_bid   = bid;
        m_cnt[sid]++;
        m_ask[sid] = ask;
        m_bid[sid] = bid;
      end
    end
    for (int s = 0; s < NS; s++) e_full[s] = (m_cnt[s] >= BS);
  endtask

  // Drive one cycle from posedge+1; outputs sampled at next posedge+1.
  task automatic step(input logic v, input logic [1:0] s, input logic [DW-1:0] a, b,
                      input logic f, input logic [1:0] fs);
    valid = v; sid = s; ask = a; bid = b; flush = f; fsid = fs;
    #1 s_ready = ready;
    @(posedge clk);
    model_edge(!rst_n);
    #1;
    valid = 1'b0;
    flush = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    step(1'b1, 2'd1, 32'd10, 32'd5, 1'b0, 2'd0);
    step(1'b0, 2'd0, 32'd0, 32'd0, 1'b0, 2'd0);
    total++;
    if (obs !== '0) $display("FAIL reset_outputs got %h want 0", obs); else passed++;
    total++;
    if (s_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", s_ready); else passed++;
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 2'd2, 32'(101+i), 32'(99+i), 1'b0, 2'd0);
      total++;
      if ({o_valid, o_addr, o_sid, o_ask, o_full} !== {1'b1, 7'(40+i), 2'd2, 32'(101+i), 4'b0})
        $display("FAIL basic_write%0d got v=%b a=%0d s=%0d ask=%0d full=%b want v=1 a=%0d",
                 i, o_valid, o_addr, o_sid, o_ask, o_full, 40+i);
      else passed++;
    end
    step(1'b0, 2'd2, 32'd0, 32'd0, 1'b0, 2'd0);
    total++;
    if ({o_valid, o_addr, o_bid} !== {1'b0, 7'd42, 32'd101})
      $display("FAIL basic_hold got v=%b a=%0d bid=%0d want v=0 a=42 bid=101", o_valid, o_addr, o_bid);
    else passed++;
  endtask

  task automatic test_wrap;
    for (int i = 0; i < 21; i++) begin
      step(1'b1, 2'd1, 32'(200+i), 32'd100, 1'b0, 2'd0);
      total++;
      if ({o_valid, o_addr, o_full[1]} !== {1'b1, 7'(20 + i % 20), 1'(i >= 19)})
        $display("FAIL wrap_write%0d got v=%b a=%0d full1=%b want a=%0d full1=%b",
                 i, o_valid, o_addr, o_full[1], 20 + i % 20, i >= 19);
      else passed++;
    end
  endtask

  task automatic test_dup;
    logic [DW-1:0] asks [3] = '{32'd100, 32'd100, 32'd100};
    logic [DW-1:0] bids [3] = '{32'd99, 32'd99, 32'd98};
    logic [2:0]    vexp = 3'b101;
    logic [6:0]    aexp [3] = '{7'd0, 7'd0, 7'd1};
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 2'd0, asks[i], bids[i], 1'b0, 2'd0);
      total++;
      if ({o_valid, o_addr} !== {vexp[2-i], aexp[i]})
        $display("FAIL dup_step%0d got v=%b a=%0d want v=%b a=%0d", i, o_valid, o_addr, vexp[2-i], aexp[i]);
      else passed++;
    end
  endtask

  task automatic test_crossed;
    step(1'b1, 2'd3, 32'd50, 32'd60, 1'b0, 2'd0);
    total++;
    if ({o_crossed, o_valid} !== 2'b10)
      $display("FAIL crossed_pulse got c=%b v=%b want c=1 v=0", o_crossed, o_valid);
    else passed++;
    step(1'b1, 2'd3, 32'd70, 32'd65, 1'b0, 2'd0);
    total++;
    if ({o_crossed, o_valid, o_addr} !== {2'b01, 7'd60})
      $display("FAIL crossed_next got c=%b v=%b a=%0d want c=0 v=1 a=60", o_crossed, o_valid, o_addr);
    else passed++;
    step(1'b1, 2'd3, 32'd55, 32'd55, 1'b0, 2'd0);
    total++;
    if ({o_crossed, o_valid, o_addr} !== {2'b01, 7'd61})
      $display("FAIL equal_quote got c=%b v=%b a=%0d want c=0 v=1 a=61", o_crossed, o_valid, o_addr);
    else passed++;
  endtask

  task automatic test_flush;
    total++;
    if (o_full[1] !== 1'b1) $display("FAIL preflush_full got %b want 1", o_full[1]); else passed++;
    step(1'b1, 2'd1, 32'd220, 32'd100, 1'b1, 2'd1);
    total++;
    if ({s_ready, o_valid, o_full[1]} !== 3'b000)
      $display("FAIL flush_cycle got rdy=%b v=%b full1=%b want 0 0 0", s_ready, o_valid, o_full[1]);
    else passed++;
    step(1'b1, 2'd1, 32'd220, 32'd100, 1'b0, 2'd0);
    total++;
    if ({o_valid, o_addr} !== {1'b1, 7'd20})
      $display("FAIL flush_rewrite got v=%b a=%0d want v=1 a=20", o_valid, o_addr);
    else passed++;
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 5; i++) step(1'b1, 2'd0, 32'(300+i), 32'd1, 1'b0, 2'd0);
    rst_n = 1'b0;
    step(1'b1, 2'd0, 32'd999, 32'd1, 1'b0, 2'd0);
    total++;
    if (obs !== '0) $display("FAIL midreset_outputs got %h want 0", obs); else passed++;
    rst_n = 1'b1;
    step(1'b1, 2'd0, 32'd400, 32'd300, 1'b0, 2'd0);
    total++;
    if ({o_valid, o_addr} !== {1'b1, 7'd0})
      $display("FAIL midreset_restart got v=%b a=%0d want v=1 a=0", o_valid, o_addr);
    else passed++;
  endtask

  task automatic test_random;
    for (int i = 0; i < 400; i++) begin
      logic f;
      f = ($urandom_range(0, 15) == 0);
      step(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
           32'($urandom_range(10, 13)), 32'($urandom_range(9, 12)), f, 2'($urandom_range(0, 3)));
      total++;
      if (obs !== exp_v || s_ready !== !f)
        $display("FAIL random%0d got %h rdy=%b want %h rdy=%b", i, obs, s_ready, exp_v, !f);
      else passed++;
    end
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_wrap();
    test_dup();
    test_crossed();
    test_flush();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
